// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared definitions for the single-precision FP multiplier
// back end. Holds special-value class and rounding-mode encodings,
// binary32 format constants, flag bit positions and a small packing helper.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'b00,
        CLS_ZERO   = 2'b01,
        CLS_INF    = 2'b10,
        CLS_NAN    = 2'b11
    } fp_class_e;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,   // nearest, ties to even
        RM_RTZ = 2'b01,   // toward zero
        RM_RUP = 2'b10,   // toward +inf
        RM_RDN = 2'b11    // toward -inf
    } fp_rm_e;

    localparam int          BIAS       = 127;
    localparam int          EXP_MAX    = 255;
    localparam int          EXP_FLD_W  = 8;
    localparam int          FRAC_FLD_W = 23;
    localparam logic [31:0] QNAN       = 32'h7FC0_0000;

    // out_flags = {overflow, underflow, inexact}
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    function automatic logic [31:0] fp_inf(input logic sign);
        return {sign, 8'hFF, 23'h0};
    endfunction

    function automatic logic [31:0] fp_zero(input logic sign);
        return {sign, 31'h0};
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// fp_round_pack: combinational round / range-check / pack of a normalised
// mantissa into an IEEE-754 binary32 word. Shared with the future FP adder.
//
// Ports:
//   sign   in   result sign
//   cls    in   special-value class (fp_class_e)
//   man    in   FRAC_W fraction bits after normalisation (hidden bit dropped)
//   g, st  in   guard and sticky bits below the fraction
//   e_in   in   signed biased exponent before rounding
//   rm     in   rounding mode, only with FP_ROUND_MODES_EN defined
//   result out  packed binary32
//   flags  out  {overflow, underflow, inexact}
//
// Optional feature macro: FP_ROUND_MODES_EN (adds rm, directed rounding and
// overflow saturation to max-finite). Without it the block rounds RNE only.
module fp_round_pack
    import fp_mul_pkg::*;
#(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 23
) (
    input  logic                    sign,
    input  logic [1:0]              cls,
    input  logic [FRAC_W-1:0]       man,
    input  logic                    g,
    input  logic                    st,
    input  logic signed [EXP_W-1:0] e_in,
`ifdef FP_ROUND_MODES_EN
    input  logic [1:0]              rm,
`endif
    output logic [31:0]             result,
    output logic [2:0]              flags
);

    localparam logic signed [EXP_W-1:0] E_MAX = EXP_W'(EXP_MAX);
    localparam logic signed [EXP_W-1:0] E_MIN = EXP_W'(1);

    logic                    round_up;
    logic                    sat;      // overflow goes to max-finite, not inf
    logic                    carry;
    logic [FRAC_W-1:0]       man_r;
    logic signed [EXP_W-1:0] exp_r;
    logic                    inexact;

    assign inexact = g | st;

    always_comb begin
        round_up = g & (st | man[0]);
        sat      = 1'b0;
`ifdef FP_ROUND_MODES_EN
        case (rm)
            RM_RNE: round_up = g & (st | man[0]);
            RM_RTZ: round_up = 1'b0;
            RM_RUP: round_up = ~sign & inexact;
            RM_RDN: round_up = sign & inexact;
            default: round_up = 1'b0;
        endcase
        // Modes that never round away from zero on this sign stop at max-finite.
        sat = (rm == RM_RTZ) | ((rm == RM_RUP) & sign) | ((rm == RM_RDN) & ~sign);
`endif
    end

    // All-ones fraction plus one carries into the exponent and leaves man_r=0.
    assign {carry, man_r} = {1'b0, man} + {{FRAC_W{1'b0}}, round_up};
    assign exp_r          = e_in + {{(EXP_W-1){1'b0}}, carry};

    always_comb begin
        result = '0;
        flags  = '0;
        case (cls)
            CLS_ZERO: result = fp_zero(sign);
            CLS_INF:  result = fp_inf(sign);
            CLS_NAN:  result = QNAN;
            default: begin
                if (exp_r >= E_MAX) begin
                    result          = sat ? {sign, 8'hFE, 23'h7F_FFFF} : fp_inf(sign);
                    flags[FLG_OVF]  = 1'b1;
                    flags[FLG_INX]  = 1'b1;
                end else if (exp_r < E_MIN) begin
                    // No subnormal output: anything below the normal range flushes.
                    result          = fp_zero(sign);
                    flags[FLG_UNF]  = 1'b1;
                    flags[FLG_INX]  = 1'b1;
                end else begin
                    result          = {sign, exp_r[EXP_FLD_W-1:0], man_r[FRAC_W-1 -: FRAC_FLD_W]};
                    flags[FLG_INX]  = inexact;
                end
            end
        endcase
    end

endmodule

// File: rtl/fp_mul_norm_round.sv
// fp_mul_norm_round: two-stage normalise + round/pack stage behind the
// 24x24 mantissa multiplier of the binary32 FP multiplier.
//   stage 1: pick the product's leading bit, extract fraction/guard/sticky,
//            adjust exponent.
//   stage 2: round, range check and pack (fp_round_pack), registered output.
// Valid/ready on both sides, one result per cycle, 2-cycle latency.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   in_sign             result sign
//   in_exp              signed exponent sum ea+eb-127
//   in_prod             unsigned 2*MAN_W mantissa product (top two bits != 00
//                       for the normal class)
//   in_class            fp_class_e
//   rm                  rounding mode, only with FP_ROUND_MODES_EN defined
//   out_valid/out_ready downstream handshake
//   out_result          packed binary32
//   out_flags           {overflow, underflow, inexact}
//
// Optional feature macro: FP_ROUND_MODES_EN.
// The packed output is binary32, so MAN_W is expected to stay at 24.
module fp_mul_norm_round
    import fp_mul_pkg::*;
#(
    parameter int EXP_W = 10,
    parameter int MAN_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [2*MAN_W-1:0]      in_prod,
    input  logic [1:0]              in_class,
`ifdef FP_ROUND_MODES_EN
    input  logic [1:0]              rm,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_result,
    output logic [2:0]              out_flags
);

    localparam int PROD_W = 2 * MAN_W;
    localparam int FRAC_W = MAN_W - 1;
    // One extra bit so the +1 from normalising and the +1 from rounding can
    // never wrap, whatever EXP_W is chosen.
    localparam int EI_W   = EXP_W + 1;

    typedef struct packed {
        logic              sign;
        logic [1:0]        cls;
        logic [FRAC_W-1:0] man;
        logic              g;
        logic              st;
        logic [EI_W-1:0]   exp;
`ifdef FP_ROUND_MODES_EN
        logic [1:0]        rm;
`endif
    } s1_t;

    logic [2:1]  vld_pipe;   // [1] stage-1 register, [2] output register
    logic        s2_advance;
    s1_t         s1_d, s1_q;
    logic [31:0] rp_result;
    logic [2:0]  rp_flags;

    assign out_valid  = vld_pipe[2];
    assign s2_advance = ~vld_pipe[2] | out_ready;
    assign in_ready   = ~vld_pipe[1] | s2_advance;

    // Stage 1: normalise. The product of two [1,2) mantissas lies in [1,4),
    // so the leading one is at bit PROD_W-1 or PROD_W-2.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_sign;
        s1_d.cls  = in_class;
`ifdef FP_ROUND_MODES_EN
        s1_d.rm   = rm;
`endif
        if (in_prod[PROD_W-1]) begin
            s1_d.man = in_prod[PROD_W-2 -: FRAC_W];
            s1_d.g   = in_prod[MAN_W-1];
            s1_d.st  = |in_prod[MAN_W-2:0];
            s1_d.exp = {in_exp[EXP_W-1], in_exp} + {{EXP_W{1'b0}}, 1'b1};
        end else begin
            s1_d.man = in_prod[PROD_W-3 -: FRAC_W];
            s1_d.g   = in_prod[MAN_W-2];
            s1_d.st  = |in_prod[MAN_W-3:0];
            s1_d.exp = {in_exp[EXP_W-1], in_exp};
        end
    end

    fp_round_pack #(
        .EXP_W  (EI_W),
        .FRAC_W (FRAC_W)
    ) u_round_pack (
        .sign   (s1_q.sign),
        .cls    (s1_q.cls),
        .man    (s1_q.man),
        .g      (s1_q.g),
        .st     (s1_q.st),
        .e_in   ($signed(s1_q.exp)),
`ifdef FP_ROUND_MODES_EN
        .rm     (s1_q.rm),
`endif
        .result (rp_result),
        .flags  (rp_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            s1_q       <= '0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            if (in_ready) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            // Output register only loads on advance, so a stalled result holds.
            if (s2_advance) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_result <= rp_result;
                    out_flags  <= rp_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Self-checking bench for fp_mul_norm_round: directed vector table, backpressure
// and mid-stream reset sequences, then randomized traffic against a reference
// model that rounds with integer quotient/remainder arithmetic.
module tb_fp_mul_norm_round;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sign = 1'b0;
    logic signed [9:0] in_exp = '0;
    logic [47:0]       in_prod = '0;
    logic [1:0]        in_class = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [31:0]       out_result;
    logic [2:0]        out_flags;
`ifdef FP_ROUND_MODES_EN
    logic [1:0]        rm = 2'b00;
`endif

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_mul_norm_round dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_prod    (in_prod),
        .in_class   (in_class),
`ifdef FP_ROUND_MODES_EN
        .rm         (rm),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    typedef struct {
        logic        sign;
        int          exp;
        logic [47:0] prod;
        logic [1:0]  cls;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
    } exp_t;

    localparam int NV = 17;
    vec_t tbl [NV];
    exp_t sb [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        in_sign  = v.sign;
        in_exp   = v.exp[9:0];
        in_prod  = v.prod;
        in_class = v.cls;
    endtask

    // Reference: value = prod * 2^(exp-127-46). Keep the 24 most significant
    // bits as an integer quotient, round from the discarded remainder.
    function automatic exp_t ref_model(input logic s, input int e_in,
                                       input logic [47:0] p, input logic [1:0] c);
        exp_t r;
        longint unsigned pv, q, rem, half;
        int sh, e;
        logic inx;
        logic [31:0] ebits;
        r.flg = 3'b000;
        case (c)
            2'b01: r.res = {s, 31'h0};
            2'b10: r.res = {s, 8'hFF, 23'h0};
            2'b11: r.res = 32'h7FC0_0000;
            default: begin
                pv   = 64'(p);
                sh   = (pv >= (64'd1 << 47)) ? 24 : 23;
                e    = e_in + sh - 23;
                q    = pv >> sh;
                rem  = pv - (q << sh);
                half = 64'd1 << (sh - 1);
                inx  = (rem != 0);
                if (rem > half || (rem == half && q[0])) q = q + 1;
                if (q == (64'd1 << 24)) begin
                    q = q >> 1;
                    e = e + 1;
                end
                ebits = e;
                if (e >= 255) begin
                    r.res = {s, 8'hFF, 23'h0};
                    r.flg = 3'b101;
                end else if (e <= 0) begin
                    r.res = {s, 31'h0};
                    r.flg = 3'b011;
                end else begin
                    r.res = {s, ebits[7:0], q[22:0]};
                    r.flg = {2'b00, inx};
                end
            end
        endcase
        return r;
    endfunction

    // One vector through an idle pipe; checks latency as well as the result.
    task automatic run_one(input vec_t v, input int idx);
        @(negedge clk);
        drive(v);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk($sformatf("vec%0d in_ready", idx), in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("vec%0d early valid", idx), out_valid, 0);
        @(negedge clk);
        chk($sformatf("vec%0d out_valid", idx), out_valid, 1);
        chk($sformatf("vec%0d result", idx), out_result, v.res);
        chk($sformatf("vec%0d flags", idx), out_flags, v.flg);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 127, 48'h9000_0000_0000, 2'b00, 32'h4010_0000, 3'b000}; // 1.5*1.5
        tbl[1]  = '{1'b0, 127, 48'h4000_0000_0000, 2'b00, 32'h3F80_0000, 3'b000}; // 1.0*1.0
        tbl[2]  = '{1'b0, 127, 48'h4000_00C0_0000, 2'b00, 32'h3F80_0002, 3'b001}; // tie, odd -> up
        tbl[3]  = '{1'b0, 127, 48'h4000_0040_0000, 2'b00, 32'h3F80_0000, 3'b001}; // tie, even -> hold
        tbl[4]  = '{1'b0, 254, 48'h8000_0000_0000, 2'b00, 32'h7F80_0000, 3'b101}; // overflow
        tbl[5]  = '{1'b0, -1,  48'h4000_0000_0000, 2'b00, 32'h0000_0000, 3'b011}; // underflow
        tbl[6]  = '{1'b0, 127, 48'h4000_0000_0000, 2'b11, 32'h7FC0_0000, 3'b000}; // nan
        tbl[7]  = '{1'b1, 300, 48'h8000_0000_0000, 2'b01, 32'h8000_0000, 3'b000}; // -zero
        tbl[8]  = '{1'b1, -50, 48'h4000_0000_0000, 2'b10, 32'hFF80_0000, 3'b000}; // -inf
        tbl[9]  = '{1'b0, 127, 48'hFFFF_FF80_0000, 2'b00, 32'h4080_0000, 3'b001}; // mantissa carry
        tbl[10] = '{1'b1, 253, 48'hFFFF_FF80_0000, 2'b00, 32'hFF80_0000, 3'b101}; // carry to overflow
        tbl[11] = '{1'b0, -1,  48'hFFFF_FF80_0000, 2'b00, 32'h0080_0000, 3'b001}; // carry out of e=0
        tbl[12] = '{1'b0, 1,   48'h4000_0000_0000, 2'b00, 32'h0080_0000, 3'b000}; // min normal
        tbl[13] = '{1'b1, 0,   48'h4000_0000_0000, 2'b00, 32'h8000_0000, 3'b011}; // e=0 flush
        tbl[14] = '{1'b0, 254, 48'h4000_0000_0000, 2'b00, 32'h7F00_0000, 3'b000}; // max exponent
        tbl[15] = '{1'b1, 127, 48'h4000_0060_0000, 2'b00, 32'hBF80_0001, 3'b001}; // above half -> up
        tbl[16] = '{1'b0, 127, 48'h4000_0000_0001, 2'b00, 32'h3F80_0000, 3'b001}; // sticky only

        // Reset state
        #1;
        chk("rst out_valid", out_valid, 0);
        chk("rst out_result", out_result, 0);
        chk("rst out_flags", out_flags, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst in_ready", in_ready, 1);

        // Directed table
        for (int i = 0; i < NV; i++) run_one(tbl[i], i);

        // Backpressure: 4 inputs, out_ready low for the first 6 cycles
        begin
            int sent, got;
            sent = 0;
            got  = 0;
            for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
                @(negedge clk);
                out_ready = (cyc >= 6);
                in_valid  = (sent < 4);
                if (sent < 4) drive(tbl[sent]);
                #1;
                if (cyc == 2) chk("bp in_ready low", in_ready, 0);
                if (cyc >= 2 && cyc < 6)
                    chk($sformatf("bp hold c%0d", cyc), {out_valid, out_result, out_flags},
                        {1'b1, tbl[0].res, tbl[0].flg});
                if (out_valid && out_ready) begin
                    chk($sformatf("bp order %0d", got), {out_result, out_flags},
                        {tbl[got].res, tbl[got].flg});
                    chk($sformatf("bp cycle %0d", got), cyc, 6 + got);
                    got++;
                end
                if (in_valid && in_ready) sent++;
            end
            chk("bp count", got, 4);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            chk("bp no dup", out_valid, 0);
        end

        // Reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(tbl[0]);
        @(negedge clk);
        drive(tbl[1]);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mid full out_valid", out_valid, 1);
        chk("mid full in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst out_result", out_result, 0);
        chk("mid rst out_flags", out_flags, 0);
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("mid post in_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mid stale %0d", i), out_valid, 0);
        end

        // Randomized traffic against the reference model
        begin
            logic pend;
            vec_t v;
            exp_t e;
            longint unsigned a, b, p;
            pend = 1'b0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                @(negedge clk);
                if (!pend) begin
                    if ($urandom_range(0, 3) != 0) begin
                        a = 64'($urandom_range(24'hFF_FFFF, 24'h80_0000));
                        b = 64'($urandom_range(24'hFF_FFFF, 24'h80_0000));
                        p = a * b;
                        v.prod = p[47:0];
                        if ($urandom_range(0, 3) == 0) v.prod[21:0] = 22'h0;
                        v.sign = 1'($urandom_range(0, 1));
                        case ($urandom_range(0, 2))
                            0: v.exp = int'($urandom_range(0, 10)) - 4;
                            1: v.exp = int'($urandom_range(248, 256));
                            default: v.exp = int'($urandom_range(0, 510)) - 127;
                        endcase
                        v.cls = ($urandom_range(0, 7) < 5) ? 2'b00 : 2'($urandom_range(1, 3));
                        drive(v);
                        in_valid = 1'b1;
                        pend = 1'b1;
                    end else begin
                        in_valid = 1'b0;
                    end
                end
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("rnd spurious", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("rnd c%0d", cyc), {out_result, out_flags}, {e.res, e.flg});
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back(ref_model(in_sign, int'(in_exp), in_prod, in_class));
                    pend = 1'b0;
                end
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            for (int i = 0; i < 10 && sb.size() > 0; i++) begin
                @(negedge clk);
                #1;
                if (out_valid) begin
                    e = sb.pop_front();
                    chk("rnd drain", {out_result, out_flags}, {e.res, e.flg});
                end
            end
            chk("rnd left over", sb.size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
